// File: rtl/cnn_mac_pipe_sat.sv
// Pipelined signed MAC: registered product pipeline, last-framed accumulation,
// round-half-up requantisation and saturation to the output width.
module cnn_mac_pipe_sat #(
  parameter int DIN0_WIDTH = 9,
  parameter int DIN1_WIDTH = 14,
  parameter int MUL_STAGES = 2,
  parameter int ACC_WIDTH  = 32,
  parameter int FRAC_SHIFT = 8,
  parameter int DOUT_WIDTH = 14
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  sat_flag
);
  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  localparam logic signed [ACC_WIDTH:0] RND  = ((ACC_WIDTH+1)'(1) << FRAC_SHIFT) >> 1;
  localparam logic signed [ACC_WIDTH:0] DMAX = (ACC_WIDTH+1)'((64'sd1 <<< (DOUT_WIDTH-1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH:0] DMIN = -DMAX - (ACC_WIDTH+1)'(1);

  logic signed [DIN0_WIDTH-1:0] a;
  logic signed [DIN1_WIDTH-1:0] b;
  logic signed [PW-1:0]         prod;
  assign a    = din0;
  assign b    = din1;
  assign prod = PW'(a) * PW'(b);

  logic signed [PW-1:0]  p_pipe [MUL_STAGES];
  logic [MUL_STAGES-1:0] vld_pipe, lst_pipe;

  // Product, valid and last move as one bundle; bubbles just carry vld=0.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      vld_pipe <= '0;
      lst_pipe <= '0;
    end else if (ce) begin
      vld_pipe[0] <= in_valid;
      lst_pipe[0] <= in_last;
      p_pipe[0]   <= prod;
      for (int i = 1; i < MUL_STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        lst_pipe[i] <= lst_pipe[i-1];
        p_pipe[i]   <= p_pipe[i-1];
      end
    end
  end

  logic                         acc_empty;
  logic signed [ACC_WIDTH-1:0]  acc, pe, sum;
  logic signed [ACC_WIDTH:0]    rnd_sum, r;
  logic                         sat_hi, sat_lo;
  logic [DOUT_WIDTH-1:0]        dnext;

  // Rounding add is one bit wider than the accumulator so it cannot wrap.
  always_comb begin
    pe      = ACC_WIDTH'(p_pipe[MUL_STAGES-1]);
    sum     = acc_empty ? pe : acc + pe;
    rnd_sum = (ACC_WIDTH+1)'(sum) + RND;
    r       = rnd_sum >>> FRAC_SHIFT;
    sat_hi  = r > DMAX;
    sat_lo  = r < DMIN;
    dnext   = r[DOUT_WIDTH-1:0];
    if (sat_hi) dnext = DMAX[DOUT_WIDTH-1:0];
    if (sat_lo) dnext = DMIN[DOUT_WIDTH-1:0];
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc_empty  <= 1'b1;
      acc        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sat_flag   <= 1'b0;
    end else if (ce) begin
      dout_valid <= 1'b0;
      if (vld_pipe[MUL_STAGES-1]) begin
        if (lst_pipe[MUL_STAGES-1]) begin
          dout       <= dnext;
          dout_valid <= 1'b1;
          sat_flag   <= sat_hi | sat_lo;
          acc_empty  <= 1'b1;
        end else begin
          acc       <= sum;
          acc_empty <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_cnn_mac_pipe_sat.sv
// Bench for cnn_mac_pipe_sat: directed plan cases then random traffic against
// an arithmetic model that tracks expected results by ce-enabled edge count.
module tb_cnn_mac_pipe_sat;
  localparam int W0 = 9, W1 = 14, MS = 2, AW = 32, FS = 8, DW = 14;

  logic ap_clk = 1'b0, ap_rst = 1'b0, ce = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [W0-1:0] din0 = '0;
  logic [W1-1:0] din1 = '0;
  logic [DW-1:0] dout;
  logic dout_valid, sat_flag;

  cnn_mac_pipe_sat #(.DIN0_WIDTH(W0), .DIN1_WIDTH(W1), .MUL_STAGES(MS),
    .ACC_WIDTH(AW), .FRAC_SHIFT(FS), .DOUT_WIDTH(DW)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid), .in_last(in_last),
    .din0(din0), .din1(din1), .dout(dout), .dout_valid(dout_valid), .sat_flag(sat_flag));

  always #5 ap_clk = ~ap_clk;

  int checks = 0, failures = 0, edges = 0;
  longint macc = 0;
  bit mempty = 1'b1;
  int            q_due [$];
  logic [DW-1:0] q_dout [$];
  logic          q_sat [$];
  logic [DW-1:0] prev_dout;
  logic          prev_v, prev_s;

  function automatic longint wrap(input longint x);
    return (x <<< (64 - AW)) >>> (64 - AW);
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive, clock, then update the model and compare 1ns after the edge.
  task automatic cyc(input bit c, input bit rst, input bit v, input bit l,
                     input int x0, input int x1);
    longint p, s, r, hi, lo;
    logic [DW-1:0] ed;
    logic es;
    ce = c; ap_rst = rst; in_valid = v; in_last = l;
    din0 = W0'(x0); din1 = W1'(x1);
    prev_dout = dout; prev_v = dout_valid; prev_s = sat_flag;
    @(posedge ap_clk); #1;
    if (rst) begin
      q_due.delete(); q_dout.delete(); q_sat.delete();
      mempty = 1'b1; macc = 0;
      chk("rst_valid", dout_valid, 0); chk("rst_dout", dout, 0); chk("rst_sat", sat_flag, 0);
    end else if (c) begin
      edges++;
      if (v) begin
        p = longint'($signed(din0)) * longint'($signed(din1));
        s = mempty ? wrap(p) : wrap(macc + p);
        if (l) begin
          r  = (FS == 0) ? s : ((s + (64'sd1 <<< (FS - 1))) >>> FS);
          hi = (64'sd1 <<< (DW - 1)) - 1;
          lo = -(64'sd1 <<< (DW - 1));
          es = (r > hi) || (r < lo);
          ed = (r > hi) ? DW'(hi) : (r < lo) ? DW'(lo) : DW'(r);
          q_due.push_back(edges + MS); q_dout.push_back(ed); q_sat.push_back(es);
          mempty = 1'b1;
        end else begin
          macc = s; mempty = 1'b0;
        end
      end
      if (q_due.size() > 0 && q_due[0] == edges) begin
        chk("dout_valid", dout_valid, 1);
        chk("dout", $signed(dout), $signed(q_dout[0]));
        chk("sat_flag", sat_flag, q_sat[0]);
        void'(q_due.pop_front()); void'(q_dout.pop_front()); void'(q_sat.pop_front());
      end else begin
        chk("no_valid", dout_valid, 0);
      end
    end else begin
      chk("hold_dout", dout, prev_dout);
      chk("hold_valid", dout_valid, prev_v);
      chk("hold_sat", sat_flag, prev_s);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 5, 5);
    idle(2);
    // single element, 3 edges to output
    cyc(1, 0, 1, 1, 3, 256);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("plan_single", $signed(dout), 3);
    idle(3);
    // rounding
    cyc(1, 0, 1, 1, 1, 128);
    cyc(1, 0, 1, 1, 1, 127);
    cyc(1, 0, 1, 1, -1, 128);
    idle(4);
    // positive / negative saturation
    cyc(1, 0, 1, 1, -256, -8192);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, i == 3, -256, 8191);
    idle(4);
    // bubbles and ce gaps
    cyc(1, 0, 1, 0, 2, 256);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 9, 9);
    cyc(0, 0, 1, 1, 9, 9);
    cyc(1, 0, 1, 0, 3, 256);
    cyc(1, 0, 0, 1, 50, 50);
    cyc(1, 0, 1, 1, -1, 256);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("plan_bubble", $signed(dout), 4);
    cyc(0, 0, 0, 0, 0, 0);
    idle(3);
    // back-to-back vectors
    cyc(1, 0, 1, 1, 5, 256);
    cyc(1, 0, 1, 0, 7, 256);
    cyc(1, 0, 1, 1, 1, 256);
    idle(4);
    // reset mid-vector
    cyc(1, 0, 1, 0, 10, 256);
    cyc(1, 0, 1, 0, 10, 256);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 1, 256);
    idle(2);
    chk("plan_reset", $signed(dout), 1);
    idle(3);
    // random traffic
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 199) == 0,
          $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
          int'($urandom), int'($urandom));
    idle(MS + 3);
    chk("drained", q_due.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cnn_mac_pipe_sat.md
Name: cnn_mac_pipe_sat

Overview:
Parametrised, pipelined signed multiply-accumulate unit for CNN convolution and dense layers. It is the successor to the fixed 9s x 14s combinational multiplier. It adds configurable operand widths, a registered multiply pipeline, vector accumulation framed by a last flag, round-half-up requantisation, and saturation to the layer's fixed-point output width. It sits between the weight/activation streams and the layer output buffer.

Parameters:
DIN0_WIDTH, 9, signed weight operand width (2..18)
DIN1_WIDTH, 14, signed activation operand width (2..25)
MUL_STAGES, 2, product pipeline register stages (1..4)
ACC_WIDTH, 32, accumulator width; must be >= DIN0_WIDTH+DIN1_WIDTH
FRAC_SHIFT, 8, arithmetic right shift applied at requantisation (0..ACC_WIDTH-2)
DOUT_WIDTH, 14, signed output width

Ports:
ap_clk     in   1            clock; all logic rising-edge
ap_rst     in   1            synchronous active-high reset
ce         in   1            clock enable; when 0, every register holds its value
in_valid   in   1            din0/din1/in_last are valid this cycle (sampled only when ce=1)
in_last    in   1            final element of the current vector
din0       in   DIN0_WIDTH   signed weight
din1       in   DIN1_WIDTH   signed activation
dout       out  DOUT_WIDTH   requantised, saturated vector result
dout_valid out  1            dout holds a new result
sat_flag   out  1            dout was clipped; qualified by dout_valid

Behaviour:
- One clock, ap_clk. ap_rst is synchronous, active-high, and has priority over ce.
- Reset state: pipeline valid bits 0, accumulator marked empty, dout=0, dout_valid=0, sat_flag=0.
- Multiply pipeline: full-precision product p = signed(din0)*signed(din1), DIN0_WIDTH+DIN1_WIDTH bits.
  - p, valid and last travel together through MUL_STAGES registers.
  - The pipeline advances only when ce=1.
  - A cycle with in_valid=0 injects a bubble. Bubbles never touch the accumulator.
- Accumulate stage, on a valid product (ce=1), with p sign-extended to ACC_WIDTH:
  - Accumulator empty: sum = p.
  - Otherwise: sum = acc + p, modulo 2^ACC_WIDTH (two's-complement wrap; no internal saturation).
  - last=0: acc <= sum, accumulator becomes non-empty.
  - last=1: requantise sum into dout, and return the accumulator to empty in the same cycle.
- Requantise:
  - r = (sum + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, arithmetic shift (round half toward +inf). For FRAC_SHIFT=0, r = sum.
  - The rounding add is computed at ACC_WIDTH+1 bits so that it cannot wrap.
  - If r > 2^(DOUT_WIDTH-1)-1: dout = max, sat_flag=1.
  - If r < -2^(DOUT_WIDTH-1): dout = min, sat_flag=1.
  - Otherwise dout = r[DOUT_WIDTH-1:0], sat_flag=0.
- Output timing:
  - dout_valid=1 on the ce-enabled edge that registers a result.
  - It falls to 0 on the next ce-enabled edge unless another last arrives.
  - While ce=0, dout, dout_valid and sat_flag hold.
- Latency: the in_last sample to dout_valid=1 takes MUL_STAGES+1 ce-enabled edges.
- Throughput: one element per ce-enabled cycle.
- Back-to-back vectors are allowed: the first element of the next vector may follow a last element on the very next cycle.
- Single-element vector (in_valid=1, in_last=1 with the accumulator empty): the result is that element's product alone.
- Reset mid-vector: the partial sum and all in-flight products are discarded. No output is produced for the aborted vector.
- A valid element with in_last=0 that is never followed by a last element stays accumulated indefinitely. No timeout.

Test Plan:
- Defaults; single element din0=3, din1=256, last -> after 3 ce-enabled edges dout=3, dout_valid=1 for 1 cycle, sat_flag=0.
- Rounding:
  - din0=1, din1=128, last -> dout=1.
  - din0=1, din1=127, last -> dout=0.
  - din0=-1, din1=128, last -> dout=0.
- Positive saturation: din0=-256, din1=-8192, last -> dout=8191, sat_flag=1.
- Negative saturation: four elements din0=-256, din1=8191, last on the 4th -> dout=-8192, sat_flag=1.
- Bubbles and ce: vector (2,256), (3,256), (-1,256, last) with in_valid gaps and ce=0 for 2 cycles mid-stream -> single dout=4. Outputs hold while ce=0.
- Back-to-back and reset:
  - (5,256, last) immediately followed by (7,256), (1,256, last) -> dout=5, then dout=8, no extra dout_valid.
  - Separately: two elements (10,256), then ap_rst for 1 cycle, then (1,256, last) -> only dout=1 appears.
